// File: rtl/sc_et_counter.sv
`default_nettype none
// ============================================================================
// Module   : sc_et_counter
// Purpose  : Counts the ones in a stochastic bitstream of up to N = 2**WIDTH
//            bits and decides whether the count exceeds a threshold.
//            When SC_ET_EARLY_TERM_EN is defined, evaluation stops as soon
//            as the outcome is certain (HI / LO early termination).
//            Otherwise every evaluation consumes exactly N bits.
// Revision : 1.0 - initial release
// ============================================================================
module sc_et_counter #(
    parameter int WIDTH          = 8,
    parameter int THRESH_DEFAULT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   thresh,
    input  logic             x,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             decision,
    output logic [WIDTH:0]   ones,
    output logic [WIDTH:0]   cycles,
    output logic             early
);

    // One guard bit above the WIDTH+1 counters keeps every sum from wrapping
    localparam int              c_AW = WIDTH + 2;
    localparam logic [c_AW-1:0] c_N  = {2'b01, {WIDTH{1'b0}}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [WIDTH:0]  r_ones;
    logic [WIDTH:0]  r_cycles;
    logic [WIDTH:0]  r_thr;
    logic            r_decision;
    logic            r_early;

    logic [c_AW-1:0] w_ones_n;
    logic [c_AW-1:0] w_cyc_n;
    logic [c_AW-1:0] w_thr_ext;
    logic            w_hi;
    logic            w_full;
    logic            w_term;
    logic            w_early;
    logic            w_accept;

    assign w_ones_n  = {1'b0, r_ones} + {{(c_AW-1){1'b0}}, x};
    assign w_cyc_n   = {1'b0, r_cycles} + {{(c_AW-1){1'b0}}, 1'b1};
    assign w_thr_ext = {1'b0, r_thr};
    assign w_hi      = (w_ones_n > w_thr_ext);
    assign w_full    = (w_cyc_n == c_N);
    assign w_accept  = (r_state == c_S_IDLE) && start;

`ifdef SC_ET_EARLY_TERM_EN
    logic w_lo;
    // LO: even if every remaining bit were a one the count could not pass thr
    assign w_lo    = ((w_ones_n + (c_N - w_cyc_n)) <= w_thr_ext);
    assign w_term  = w_hi | w_lo | w_full;
    assign w_early = (w_cyc_n < c_N);
`else
    assign w_term  = w_full;
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start)      w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_term)     w_state_nxt = c_S_DONE;
            c_S_DONE: if (done_ready) w_state_nxt = c_S_IDLE;
            default:                  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Decision equals the HI test in every termination case, including FULL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones     <= '0;
            r_cycles   <= '0;
            r_thr      <= (WIDTH+1)'(THRESH_DEFAULT);
            r_decision <= 1'b0;
            r_early    <= 1'b0;
        end else if (w_accept) begin
            r_ones     <= '0;
            r_cycles   <= '0;
            r_thr      <= thresh;
            r_decision <= 1'b0;
            r_early    <= 1'b0;
        end else if (r_state == c_S_RUN) begin
            r_ones   <= w_ones_n[WIDTH:0];
            r_cycles <= w_cyc_n[WIDTH:0];
            if (w_term) begin
                r_decision <= w_hi;
                r_early    <= w_early;
            end
        end
    end

    assign busy       = (r_state == c_S_RUN);
    assign done_valid = (r_state == c_S_DONE);
    assign decision   = r_decision;
    assign ones       = r_ones;
    assign cycles     = r_cycles;
    assign early      = r_early;

endmodule
`default_nettype wire

// File: tb/tb_sc_et_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_et_counter
// Purpose  : Self-checking bench for sc_et_counter (WIDTH=8, N=256) with a
//            stream-level reference model; honours SC_ET_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sc_et_counter;
    localparam int WIDTH = 8;
    localparam int N     = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [WIDTH:0] thresh = '0;
    logic           x = 1'b0;
    logic           done_ready = 1'b0;
    logic           busy, done_valid, decision, early;
    logic [WIDTH:0] ones, cycles;

    sc_et_counter #(.WIDTH(WIDTH), .THRESH_DEFAULT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh), .x(x),
        .busy(busy), .done_valid(done_valid), .done_ready(done_ready),
        .decision(decision), .ones(ones), .cycles(cycles), .early(early)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit bits [N];
    bit chk_en = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_dv = 1'b0;
    bit exp_dec = 1'b0;
    bit exp_early = 1'b0;
    int exp_ones = 0;
    int exp_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pin(input string name, input int act, input int req_et, input int req_full);
`ifdef SC_ET_EARLY_TERM_EN
        check(name, act, req_et);
`else
        check(name, act, req_full);
`endif
    endtask

    // Per-cycle comparison against the expected protocol phase and result
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(exp_busy));
            check("done_valid", int'(done_valid), int'(exp_dv));
            if (exp_dv) begin
                check("decision", int'(decision), int'(exp_dec));
                check("ones", int'(ones), exp_ones);
                check("cycles", int'(cycles), exp_cyc);
                check("early", int'(early), int'(exp_early));
            end
        end
    end

    task automatic fill(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       bits[i] = 1'b0;
                1:       bits[i] = 1'b1;
                2:       bits[i] = (i % 2 == 0);
                default: bits[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Walk the stream sample by sample and stop at the first decisive point
    task automatic model(input int th);
        int o;
        o = 0;
        for (int k = 1; k <= N; k++) begin
            o += int'(bits[k-1]);
`ifdef SC_ET_EARLY_TERM_EN
            if (o > th || o + (N - k) <= th) begin
                exp_cyc = k; exp_ones = o; exp_dec = (o > th); exp_early = (k < N);
                return;
            end
`endif
            if (k == N) begin
                exp_cyc = k; exp_ones = o; exp_dec = (o > th); exp_early = 1'b0;
            end
        end
    endtask

    task automatic run_eval(input int th, input int kind, input int hold,
                            input bit start_in_done, input bit start_at_hs,
                            input bit rdy_in_run, input int abort_at);
        fill(kind);
        model(th);
        start = 1'b1; thresh = th[WIDTH:0]; done_ready = 1'b0;
        exp_busy = 1'b0; exp_dv = 1'b0; chk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; done_ready = rdy_in_run;
        for (int k = 0; k < exp_cyc; k++) begin
            x = bits[k]; exp_busy = 1'b1; exp_dv = 1'b0;
            if (k == abort_at) begin
                chk_en = 1'b0;
                #2 rst = 1'b1;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_done_valid", int'(done_valid), 0);
                check("rst_decision", int'(decision), 0);
                check("rst_ones", int'(ones), 0);
                check("rst_cycles", int'(cycles), 0);
                check("rst_early", int'(early), 0);
                @(negedge clk); rst = 1'b0;
                done_ready = 1'b0; exp_busy = 1'b0; exp_dv = 1'b0;
                @(posedge clk); #1;
                chk_en = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        exp_busy = 1'b0; exp_dv = 1'b1;
        for (int h = 0; h < hold; h++) begin
            done_ready = 1'b0;
            start = start_in_done && (h == hold / 2);
            x = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        done_ready = 1'b1; start = start_at_hs;
        @(posedge clk); #1;
        start = 1'b0; done_ready = 1'b0; exp_dv = 1'b0; exp_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done_valid", int'(done_valid), 0);
        check("reset_decision", int'(decision), 0);
        check("reset_ones", int'(ones), 0);
        check("reset_cycles", int'(cycles), 0);
        check("reset_early", int'(early), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        run_eval(128, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        pin("hi128_cycles", exp_cyc, 129, 256);
        pin("hi128_ones", exp_ones, 129, 256);
        pin("hi128_decision", int'(exp_dec), 1, 1);
        pin("hi128_early", int'(exp_early), 1, 0);

        run_eval(128, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        pin("lo128_cycles", exp_cyc, 128, 256);
        pin("lo128_ones", exp_ones, 0, 0);
        pin("lo128_decision", int'(exp_dec), 0, 0);

        run_eval(0, 1, 0, 1'b0, 1'b0, 1'b1, -1);
        pin("th0_cycles", exp_cyc, 1, 256);
        pin("th0_decision", int'(exp_dec), 1, 1);

        run_eval(300, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        pin("th300_cycles", exp_cyc, 1, 256);
        pin("th300_decision", int'(exp_dec), 0, 0);

        run_eval(100, 2, 10, 1'b1, 1'b0, 1'b0, -1);
        pin("alt100_cycles", exp_cyc, 201, 256);
        pin("alt100_ones", exp_ones, 101, 128);

        run_eval(255, 3, 2, 1'b0, 1'b1, 1'b1, -1);
        run_eval(511, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_eval(128, 3, 3, 1'b0, 1'b1, 1'b0, -1);
        run_eval(128, 3, 0, 1'b0, 1'b0, 1'b0, 50);
        run_eval(60, 3, 1, 1'b0, 1'b0, 1'b0, -1);
        run_eval(200, 2, 0, 1'b0, 1'b0, 1'b0, -1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
